// File: rtl/dff_pipe_hs.sv
// Valid/ready register pipeline of DEPTH stages with bubble collapse, flush and occupancy count.
// Latency: DEPTH cycles from accept to out_valid when empty; in_ready is combinational through all stages.
// Backpressure: a stage holds only while it and every stage downstream are full and out_ready is low.
module dff_pipe_hs #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] occupancy
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [DEPTH-1:0] free;
    logic             accept;
    logic             pop;

    // A stage can take new data unless it and everything after it is full and the sink stalls.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        free     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & vld_q[i];
            free[i]  = out_ready | ~all_full;
        end
    end

    assign in_ready  = free[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign pop       = vld_q[DEPTH-1] & out_ready;
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush) begin
            vld_d = '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (free[i]) begin
                    vld_d[i] = vld_q[i-1];
                    if (vld_q[i-1]) begin
                        dat_d[i] = dat_q[i-1];
                    end
                end
            end
            if (free[0]) begin
                vld_d[0] = accept;
                if (accept) begin
                    dat_d[0] = in_data;
                end
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !pop && occ_q != DEPTH_C) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!accept && pop && occ_q != '0) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= RESET_VAL;
            end
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
            dat_q <= dat_d;
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (!rst) occ_q <= DEPTH_C);
    a_out_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> $stable(out_data));

endmodule
